nonce_result_buffer: RTL and testbench



---
 rtl/hash_pkg.sv | 15 +
 rtl/result_regfile.sv | 42 ++++
 rtl/nonce_result_buffer.sv | 107 ++++++++++
 tb/tb_nonce_result_buffer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/hash_pkg.sv
// Shared constants and state encoding for the hash generator pipeline.
// Used by the result buffer, the output stage and the hash core.
package hash_pkg;

    localparam int DATA_W = 24;
    localparam int PTR_W  = 2;
    localparam int DEPTH  = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/result_regfile.sv
// Slot storage for found nonces: one write port with per-slot valid bits,
// and a registered read port that returns zero for empty slots.
module result_regfile
    import hash_pkg::*;
#(
    parameter int DATA_W = hash_pkg::DATA_W,
    parameter int DEPTH  = hash_pkg::DEPTH,
    parameter int PTR_W  = hash_pkg::PTR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              we,
    input  logic [PTR_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_dat,
    input  logic [PTR_W-1:0]  rd_ptr,
    output logic [DATA_W-1:0] rd_dat,
    output logic [DEPTH-1:0]  valid
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            valid  <= '0;
            rd_dat <= '0;
        end else begin
            // Read sees the pre-edge contents; an empty slot never leaks a stale nonce.
            rd_dat <= valid[rd_ptr] ? mem[rd_ptr] : '0;
            if (clr) begin
                valid <= '0;
            end else if (we) begin
                mem[wr_idx]   <= wr_dat;
                valid[wr_idx] <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/nonce_result_buffer.sv
// Collects one winning nonce per job entry from the hash core and flags
// all_found once every entry 0..n_max is filled; the output stage reads slots via rd_ptr.
module nonce_result_buffer
    import hash_pkg::*;
#(
    parameter int DATA_W = hash_pkg::DATA_W,
    parameter int DEPTH  = hash_pkg::DEPTH,
    parameter int PTR_W  = hash_pkg::PTR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [PTR_W-1:0]  num_entradas,
    input  logic              hit_valid,
    input  logic [PTR_W-1:0]  hit_index,
    input  logic [DATA_W-1:0] hit_nonce,
    output logic              hit_ready,
    input  logic [PTR_W-1:0]  rd_ptr,
    output logic [DATA_W-1:0] bounty,
    output logic [DEPTH-1:0]  entry_valid,
    output logic              all_found,
    output logic              busy,
    output logic              err
);

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   n_max;
    logic               accept;
    logic               in_range;
    logic               we;
    logic [DEPTH-1:0]   job_mask;
    logic [DEPTH-1:0]   hit_onehot;
    logic [DEPTH-1:0]   valid_post;

    // Start takes priority: a hit arriving with start is consumed but dropped.
    assign accept   = hit_valid && (state_q == COLLECT) && !start;
    assign in_range = (hit_index <= n_max);
    assign we       = accept && in_range && !entry_valid[hit_index];

    always_comb begin
        job_mask   = '0;
        hit_onehot = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i <= int'(n_max)) begin
                job_mask[i] = 1'b1;
            end
        end
        if (we) begin
            hit_onehot[hit_index] = 1'b1;
        end
        valid_post = entry_valid | hit_onehot;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) state_d = COLLECT;
            end
            COLLECT: begin
                if (start) begin
                    state_d = COLLECT;
                end else if ((valid_post & job_mask) == job_mask) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            n_max   <= '0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start) begin
                n_max <= num_entradas;
                err   <= 1'b0;
            end else if (accept && !in_range) begin
                err <= 1'b1;
            end
        end
    end

    assign hit_ready = (state_q == COLLECT);
    assign busy      = (state_q == COLLECT);
    assign all_found = (state_q == DONE);

    result_regfile #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_regfile (
        .clk    (clk),
        .reset  (reset),
        .clr    (start),
        .we     (we),
        .wr_idx (hit_index),
        .wr_dat (hit_nonce),
        .rd_ptr (rd_ptr),
        .rd_dat (bounty),
        .valid  (entry_valid)
    );

endmodule

// File: tb/tb_nonce_result_buffer.sv
// Directed vector table, async-reset sequence and randomized run against
// a slot/flag reference model of the nonce result buffer.
module tb_nonce_result_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  num_entradas;
    logic        hit_valid;
    logic [1:0]  hit_index;
    logic [23:0] hit_nonce;
    logic        hit_ready;
    logic [1:0]  rd_ptr;
    logic [23:0] bounty;
    logic [3:0]  entry_valid;
    logic        all_found;
    logic        busy;
    logic        err;

    int checks   = 0;
    int failures = 0;

    // reference model: slot contents, fill flags and job status
    logic [23:0] m_mem [4];
    logic [3:0]  m_valid;
    int          m_n;
    logic        m_collect;
    logic        m_done;
    logic        m_err;
    logic [23:0] m_bounty;

    nonce_result_buffer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .num_entradas (num_entradas),
        .hit_valid    (hit_valid),
        .hit_index    (hit_index),
        .hit_nonce    (hit_nonce),
        .hit_ready    (hit_ready),
        .rd_ptr       (rd_ptr),
        .bounty       (bounty),
        .entry_valid  (entry_valid),
        .all_found    (all_found),
        .busy         (busy),
        .err          (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic [1:0]  num;
        logic        hv;
        logic [1:0]  hi;
        logic [23:0] hn;
        logic [1:0]  rp;
        logic        e_rdy;
        logic        e_all;
        logic        e_err;
        logic [3:0]  e_ev;
        logic [23:0] e_bounty;
    } vec_t;

    vec_t vecs [24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_mem[i] = '0;
        m_valid   = '0;
        m_n       = 0;
        m_collect = 1'b0;
        m_done    = 1'b0;
        m_err     = 1'b0;
        m_bounty  = '0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".hit_ready"},   32'(hit_ready),   32'(m_collect));
        chk({tag, ".busy"},        32'(busy),        32'(m_collect));
        chk({tag, ".all_found"},   32'(all_found),   32'(m_done));
        chk({tag, ".err"},         32'(err),         32'(m_err));
        chk({tag, ".entry_valid"}, 32'(entry_valid), 32'(m_valid));
        chk({tag, ".bounty"},      32'(bounty),      32'(m_bounty));
    endtask

    // Drive one cycle from a negedge, advance the model, check just after the edge.
    task automatic cycle(input logic st, input logic [1:0] num, input logic hv,
                         input logic [1:0] hi, input logic [23:0] hn, input logic [1:0] rp,
                         input string tag);
        bit complete;
        start = st; num_entradas = num; hit_valid = hv;
        hit_index = hi; hit_nonce = hn; rd_ptr = rp;
        m_bounty = m_valid[rp] ? m_mem[rp] : 24'h0;
        if (st) begin
            m_n = int'(num); m_valid = '0; m_err = 1'b0;
            m_collect = 1'b1; m_done = 1'b0;
        end else if (hv && m_collect) begin
            if (int'(hi) <= m_n) begin
                if (!m_valid[hi]) begin
                    m_mem[hi]   = hn;
                    m_valid[hi] = 1'b1;
                end
            end else begin
                m_err = 1'b1;
            end
            complete = 1'b1;
            for (int i = 0; i <= m_n; i++) if (!m_valid[i]) complete = 1'b0;
            if (complete) begin
                m_collect = 1'b0;
                m_done    = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check_model(tag);
        @(negedge clk);
    endtask

    function automatic vec_t mk(logic st, logic [1:0] num, logic hv, logic [1:0] hi,
                                logic [23:0] hn, logic [1:0] rp, logic e_rdy, logic e_all,
                                logic e_err, logic [3:0] e_ev, logic [23:0] e_bounty);
        vec_t v;
        v.st = st; v.num = num; v.hv = hv; v.hi = hi; v.hn = hn; v.rp = rp;
        v.e_rdy = e_rdy; v.e_all = e_all; v.e_err = e_err; v.e_ev = e_ev; v.e_bounty = e_bounty;
        return v;
    endfunction

    initial begin
        // job of 4 entries, filled out of order, then read back
        vecs[0]  = mk(1, 3, 0, 0, 24'h0,      0, 1, 0, 0, 4'b0000, 24'h0);
        vecs[1]  = mk(0, 0, 1, 2, 24'hABCDEF, 0, 1, 0, 0, 4'b0100, 24'h0);
        vecs[2]  = mk(0, 0, 1, 0, 24'h000001, 0, 1, 0, 0, 4'b0101, 24'h0);
        vecs[3]  = mk(0, 0, 1, 3, 24'hFFFFFF, 0, 1, 0, 0, 4'b1101, 24'h000001);
        vecs[4]  = mk(0, 0, 1, 1, 24'h123456, 0, 0, 1, 0, 4'b1111, 24'h000001);
        vecs[5]  = mk(0, 0, 0, 0, 24'h0,      1, 0, 1, 0, 4'b1111, 24'h123456);
        vecs[6]  = mk(0, 0, 0, 0, 24'h0,      2, 0, 1, 0, 4'b1111, 24'hABCDEF);
        vecs[7]  = mk(0, 0, 0, 0, 24'h0,      3, 0, 1, 0, 4'b1111, 24'hFFFFFF);
        vecs[8]  = mk(0, 0, 0, 0, 24'h0,      0, 0, 1, 0, 4'b1111, 24'h000001);
        // first nonce wins on a duplicate index
        vecs[9]  = mk(1, 1, 0, 0, 24'h0,      0, 1, 0, 0, 4'b0000, 24'h000001);
        vecs[10] = mk(0, 0, 1, 1, 24'h00AA00, 1, 1, 0, 0, 4'b0010, 24'h0);
        vecs[11] = mk(0, 0, 1, 1, 24'h00BB00, 1, 1, 0, 0, 4'b0010, 24'h00AA00);
        vecs[12] = mk(0, 0, 1, 0, 24'h000010, 1, 0, 1, 0, 4'b0011, 24'h00AA00);
        vecs[13] = mk(0, 0, 0, 0, 24'h0,      0, 0, 1, 0, 4'b0011, 24'h000010);
        // out-of-range index sets sticky err; next start clears it
        vecs[14] = mk(1, 0, 0, 0, 24'h0,      0, 1, 0, 0, 4'b0000, 24'h000010);
        vecs[15] = mk(0, 0, 1, 2, 24'h111111, 0, 1, 0, 1, 4'b0000, 24'h0);
        vecs[16] = mk(0, 0, 0, 0, 24'h0,      0, 1, 0, 1, 4'b0000, 24'h0);
        vecs[17] = mk(1, 3, 0, 0, 24'h0,      0, 1, 0, 0, 4'b0000, 24'h0);
        // abort mid-job with a colliding hit
        vecs[18] = mk(0, 0, 1, 0, 24'h000005, 0, 1, 0, 0, 4'b0001, 24'h0);
        vecs[19] = mk(0, 0, 1, 1, 24'h000006, 0, 1, 0, 0, 4'b0011, 24'h000005);
        vecs[20] = mk(1, 1, 1, 3, 24'h777777, 0, 1, 0, 0, 4'b0000, 24'h000005);
        vecs[21] = mk(0, 0, 1, 1, 24'h000021, 0, 1, 0, 0, 4'b0010, 24'h0);
        vecs[22] = mk(0, 0, 1, 0, 24'h000020, 0, 0, 1, 0, 4'b0011, 24'h0);
        vecs[23] = mk(0, 0, 0, 0, 24'h0,      3, 0, 1, 0, 4'b0011, 24'h0);

        reset = 1'b1; start = 1'b0; num_entradas = '0; hit_valid = 1'b0;
        hit_index = '0; hit_nonce = '0; rd_ptr = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_model("reset");
        reset = 1'b0;

        for (int i = 0; i < 24; i++) begin
            cycle(vecs[i].st, vecs[i].num, vecs[i].hv, vecs[i].hi, vecs[i].hn, vecs[i].rp,
                  $sformatf("vec%0d", i));
            chk($sformatf("vec%0d.tbl_ready", i),  32'(hit_ready),   32'(vecs[i].e_rdy));
            chk($sformatf("vec%0d.tbl_all", i),    32'(all_found),   32'(vecs[i].e_all));
            chk($sformatf("vec%0d.tbl_err", i),    32'(err),         32'(vecs[i].e_err));
            chk($sformatf("vec%0d.tbl_ev", i),     32'(entry_valid), 32'(vecs[i].e_ev));
            chk($sformatf("vec%0d.tbl_bounty", i), 32'(bounty),      32'(vecs[i].e_bounty));
        end

        // asynchronous reset between edges while in DONE, hit_valid held high
        hit_valid = 1'b1; hit_index = 2'd2; hit_nonce = 24'h555555; rd_ptr = 2'd0;
        #2 reset = 1'b1;
        #1;
        chk("areset.bounty",      32'(bounty),      32'h0);
        chk("areset.all_found",   32'(all_found),   32'h0);
        chk("areset.entry_valid", 32'(entry_valid), 32'h0);
        chk("areset.hit_ready",   32'(hit_ready),   32'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        cycle(0, 2, 1, 2, 24'h555555, 2, "idle_hv0");
        cycle(0, 2, 1, 2, 24'h555555, 2, "idle_hv1");
        chk("idle.bounty_rd2", 32'(bounty), 32'h0);
        cycle(1, 2, 1, 2, 24'h555555, 2, "start_hv");
        chk("start_hv.ev", 32'(entry_valid), 32'h0);
        cycle(0, 2, 1, 2, 24'h555555, 2, "accept_hv");
        cycle(0, 2, 0, 0, 24'h0, 2, "read_hv");
        chk("read_hv.bounty", 32'(bounty), 32'h555555);

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 11) == 0), 2'($urandom), ($urandom_range(0, 3) != 0),
                  2'($urandom), 24'($urandom), 2'($urandom), $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
